// File: rtl/mmio_axil_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the MMIO register file.
package mmio_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mmio_axil_regfile_if.sv
// AXI4-Lite bus bundle: five channels, 32-bit address and data.
interface mmio_axil_regfile_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/mmio_axil_regfile.sv
// AXI4-Lite register file; top register is a read-only count of OKAY writes.
// Write commits one cycle after AW+W are both held; read data registered on the AR edge; B/R held until accepted.
module mmio_axil_regfile
  import mmio_axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NREGS     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_axil_regfile_if.slave    bus,
  output logic [NREGS*32-1:0]   regs_o
);

  localparam int             AIW     = $clog2(NREGS);
  localparam logic [AIW-1:0] CNT_IDX = AIW'(NREGS - 1);

  typedef struct packed {
    logic           ok;
    logic [AIW-1:0] idx;
  } dec_t;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] off;
    dec_t        d;
    off   = addr - BASE_ADDR;
    d.ok  = off < 32'(NREGS * 4);
    d.idx = off[AIW+1:2];
    return d;
  endfunction

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        rdy_en_q, rdy_en_d;

  logic        wr_pend_q, wr_pend_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  dec_t wr_dec, rd_dec;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid  && bus.wready;
  assign ar_hs = bus.arvalid && bus.arready;
  assign b_hs  = bvalid_q && bus.bready;
  assign r_hs  = bus.rvalid && bus.rready;

  // State register; rdy_en_q keeps all readies low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= IDLE;
      rd_state_q <= R_IDLE;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  // Next-state logic. RESP is entered with a commit pending; bvalid follows one edge later.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_pend_d  = 1'b0;
    rd_state_d = rd_state_q;
    rdy_en_d   = 1'b1;
    unique case (wr_state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_d = RESP;
          wr_pend_d  = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = HAVE_AW;
        end else if (w_hs) begin
          wr_state_d = HAVE_W;
        end
      end
      HAVE_AW: begin
        if (w_hs) begin
          wr_state_d = RESP;
          wr_pend_d  = 1'b1;
        end
      end
      HAVE_W: begin
        if (aw_hs) begin
          wr_state_d = RESP;
          wr_pend_d  = 1'b1;
        end
      end
      RESP: begin
        if (b_hs) wr_state_d = IDLE;
      end
      default: wr_state_d = IDLE;
    endcase
    unique case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
      R_DATA:  if (r_hs)  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.awready = rdy_en_q && (wr_state_q == IDLE || wr_state_q == HAVE_W);
    bus.wready  = rdy_en_q && (wr_state_q == IDLE || wr_state_q == HAVE_AW);
    bus.bvalid  = bvalid_q;
    bus.bresp   = bresp_q;
    bus.arready = rdy_en_q && (rd_state_q == R_IDLE);
    bus.rvalid  = (rd_state_q == R_DATA);
    bus.rdata   = rdata_q;
    bus.rresp   = rresp_q;
  end

  always_comb begin
    awaddr_d = aw_hs ? bus.awaddr : awaddr_q;
    wdata_d  = w_hs  ? bus.wdata  : wdata_q;
    wstrb_d  = w_hs  ? bus.wstrb  : wstrb_q;
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    wr_dec   = decode(awaddr_q);
    if (wr_pend_q) begin
      bvalid_d = 1'b1;
      if (!wr_dec.ok || wr_dec.idx == CNT_IDX) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_OKAY;
        cnt_d   = cnt_q + 32'd1;
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) regs_d[wr_dec.idx][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
    regs_d[NREGS-1] = '0;
  end

  // Reads sample regs_q, so a same-edge commit to the same register returns the old value.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_dec  = decode(bus.araddr);
    if (ar_hs) begin
      if (rd_dec.ok) begin
        rdata_d = (rd_dec.idx == CNT_IDX) ? cnt_q : regs_q[rd_dec.idx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (r_hs) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      wr_pend_q <= wr_pend_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NREGS; k++) begin
      regs_o[32*k +: 32] = (k == NREGS - 1) ? cnt_q : regs_q[k];
    end
  end

endmodule

// File: doc/mmio_axil_regfile.md
MMIO_AXIL_REGFILE -- requirements
Module: mmio_axil_regfile

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of register window.
REQ-002 SHALL have parameter NREGS, default 16, number of 32-bit registers (power of two, 2..64).
REQ-003 SHALL have ports: clk  in  1  sole clock; one clock; reset is asynchronous and active-low, port rst_n  in  1.
REQ-004 SHALL have AXI4-Lite write address: awvalid in 1, awready out 1, awaddr in 32.
REQ-005 SHALL have write data: wvalid in 1, wready out 1, wdata in 32, wstrb in 4.
REQ-006 SHALL have write response: bvalid out 1, bready in 1, bresp out 2.
REQ-007 SHALL have read address: arvalid in 1, arready out 1, araddr in 32.
REQ-008 SHALL have read data: rvalid out 1, rready in 1, rdata out 32, rresp out 2.
REQ-009 SHALL have regs_o  out  NREGS*32  flat register contents, reg k at bits [32k+31:32k].

Function
REQ-010 SHALL decode offset = addr - BASE_ADDR; in range iff offset < NREGS*4; index = offset[log2(NREGS)+1:2]; addr[1:0] ignored.
REQ-011 SHALL accept AW and W independently, in either order or same cycle; write FSM states IDLE, HAVE_AW, HAVE_W, RESP.
REQ-012 SHALL drive awready=1 in IDLE and HAVE_W, wready=1 in IDLE and HAVE_AW, both 0 in RESP.
REQ-013 SHALL, once both AW and W are latched (edge N), commit write and assert bvalid at edge N+1; state RESP.
REQ-014 SHALL apply wstrb per byte; wstrb=0 commits nothing but responds OKAY.
REQ-015 SHALL hold bvalid and bresp stable until bvalid&&bready, then return to IDLE; AW/W acceptance resumes the cycle after.
REQ-016 SHALL return bresp=2'b10 (SLVERR) and leave registers unchanged for out-of-range writes or writes to index NREGS-1.
REQ-017 SHALL treat index NREGS-1 as read-only 32-bit count of OKAY write completions, incremented at commit edge, wrapping 0xFFFF_FFFF->0.
REQ-018 SHALL use read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-019 SHALL, on AR handshake at edge N, register rdata and rresp at edge N and present rvalid=1 from edge N.
REQ-020 SHALL hold rvalid/rdata/rresp stable until rvalid&&rready, then R_IDLE; no back-to-back read without one idle cycle.
REQ-021 SHALL return rdata=0, rresp=SLVERR for out-of-range reads; OKAY otherwise.
REQ-022 SHALL, when write commit and AR handshake target same register on the same edge, return pre-write value.
REQ-023 SHALL operate read and write channels concurrently with no mutual stall.

Reset
REQ-024 SHALL on rst_n=0 asynchronously clear all registers, counter, regs_o, FSMs to IDLE/R_IDLE, and all outputs to 0.
REQ-025 SHALL drive awready, wready, arready to 0 while rst_n=0 and assert them the first edge after release.
REQ-026 SHALL discard any latched AW/W and pending B/R response on reset mid-transaction.

Structure
REQ-027 SHALL take RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and FSM state enums from shared package mmio_axil_pkg.
REQ-028 SHALL be a single module; no sub-module; address decode as a local function.

Verification
REQ-029 AW and W same cycle, addr 0x08, data 0xDEADBEEF, wstrb 4'hF -> bvalid after 1 cycle, bresp OKAY, regs_o[95:64]=0xDEADBEEF, counter=1.
REQ-030 W two cycles before AW, addr 0x04, data 0x12345678, wstrb 4'b0011 -> reg1=0x00005678, bresp OKAY.
REQ-031 Write addr 0x3C (index 15) or 0x40 -> bresp SLVERR, no register change, counter unchanged; read 0x40 -> rdata 0, SLVERR.
REQ-032 bready held low 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout; rvalid held stable under rready=0.
REQ-033 Write 0xAA to reg2 commit edge coincident with AR to 0x08 (old 0x55) -> rdata 0x55, next read 0xAA.
REQ-034 rst_n low mid-transaction (AW latched, W pending) -> all outputs 0 immediately; after release reg contents 0, fresh write succeeds.
